// File: rtl/rv_elastic_pipe.sv
// Elastic valid/ready register pipeline with bubble collapse, flush and occupancy count.
// DEPTH=0 degenerates to a combinational pass-through.
module rv_elastic_pipe #(
  parameter int DATAW  = 8,
  parameter int RESETW = DATAW,
  parameter int DEPTH  = 2,
  parameter int CNTW   = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready,
  output logic [CNTW-1:0]  count
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctl;
      assign unused_ctl = ^{clk, reset, flush};
      assign out_valid  = in_valid;
      assign out_data   = in_data;
      assign in_ready   = out_ready;
      assign count      = '0;
    end else begin : g_pipe
      logic [DEPTH-1:0] valid_q, valid_d;
      logic [DEPTH:0]   load;
      logic [DEPTH-1:0] vin;
      logic [DEPTH-1:0] den;
      logic [DATAW-1:0] din    [DEPTH];
      logic [DATAW-1:0] data_q [DEPTH];
      logic [CNTW-1:0]  count_q, count_d;
      logic             accept, consume;

      // Load ripples from the output side: a stage loads if it or any stage downstream can move.
      always_comb begin
        load        = '0;
        load[DEPTH] = out_ready;
        for (int unsigned j = 0; j < DEPTH; j++) begin
          load[DEPTH-1-j] = ~valid_q[DEPTH-1-j] | load[DEPTH-j];
        end
      end

      assign accept  = in_valid & load[0];
      assign consume = valid_q[DEPTH-1] & out_ready;

      always_comb begin
        vin[0] = accept;
        din[0] = in_data;
        for (int unsigned j = 1; j < DEPTH; j++) begin
          vin[j] = valid_q[j-1];
          din[j] = data_q[j-1];
        end
        valid_d = '0;
        den     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          valid_d[i] = flush ? 1'b0 : (load[i] ? vin[i] : valid_q[i]);
          den[i]     = load[i] & vin[i] & ~flush;
        end
      end

      always_comb begin
        count_d = count_q;
        if (flush) begin
          count_d = '0;
        end else if (accept && !consume) begin
          count_d = count_q + 1'b1;
        end else if (consume && !accept) begin
          count_d = count_q - 1'b1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_q <= '0;
          count_q <= '0;
        end else begin
          valid_q <= valid_d;
          count_q <= count_d;
        end
      end

      // Payload split into a reset MSB field and an unreset LSB field.
      for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (RESETW == 0) begin : g_nors
          logic [DATAW-1:0] pay_q;
          always_ff @(posedge clk) begin
            if (den[g]) pay_q <= din[g];
          end
          assign data_q[g] = pay_q;
        end else if (RESETW == DATAW) begin : g_allrs
          logic [DATAW-1:0] pay_q;
          always_ff @(posedge clk or posedge reset) begin
            if (reset)       pay_q <= '0;
            else if (den[g]) pay_q <= din[g];
          end
          assign data_q[g] = pay_q;
        end else begin : g_split
          logic [RESETW-1:0]       hi_q;
          logic [DATAW-RESETW-1:0] lo_q;
          always_ff @(posedge clk or posedge reset) begin
            if (reset)       hi_q <= '0;
            else if (den[g]) hi_q <= din[g][DATAW-1:DATAW-RESETW];
          end
          always_ff @(posedge clk) begin
            if (den[g]) lo_q <= din[g][DATAW-RESETW-1:0];
          end
          assign data_q[g] = {hi_q, lo_q};
        end
      end

      assign in_ready  = load[0];
      assign out_valid = valid_q[DEPTH-1];
      assign out_data  = data_q[DEPTH-1];
      assign count     = count_q;
    end
  endgenerate

endmodule
